seg_scan_driver: RTL and testbench

//   Parametrised N-digit multiplexed 7-segment driver; next generation of the score display.

---
 rtl/seg_scan_driver.sv | 267 ++++++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed 7-segment driver: sequential double-dabble conversion,
// internal scan prescaler, leading-zero blanking, overflow dashes and whole-display blink.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int BIN_WIDTH   = 27,
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_WIDTH-1:0]  value,
    input  logic                  value_vld,
    input  logic                  lz_blank,
    input  logic                  blink,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] seg_select,
    output logic [6:0]            seg_data
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int PW    = $clog2(CLK_DIV);
    localparam int DW    = $clog2(NUM_DIGITS + 1);
    localparam int BKW   = $clog2(BLINK_TICKS + 1);
    localparam int CW    = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = b[4*k +: 4];
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [BIN_WIDTH-1:0]  r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic [BCD_W-1:0]      w_adj;
    logic [CW-1:0]         r_cnt;
    logic                  r_ovf_next;
    logic                  r_pend_vld;
    logic [BIN_WIDTH-1:0]  r_pend_val;
    logic [BCD_W-1:0]      r_disp;
    logic                  r_ovf;
    logic                  r_busy;
    logic                  w_load;
    logic [BIN_WIDTH-1:0]  w_load_val;
    logic                  w_shift;
    logic                  w_commit;
    logic [PW-1:0]         r_presc;
    logic                  w_tick;
    logic [DW-1:0]         r_digit;
    logic [BKW-1:0]        r_blk_cnt;
    logic                  r_phase;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_sel_next;
    logic [6:0]            w_dat_next;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [6:0]            r_dat;

    // Conversion FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Conversion FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = value_vld ? S_CONV : S_IDLE;
            S_CONV:   w_state_next = (r_cnt == CW'(BIN_WIDTH - 1)) ? S_COMMIT : S_CONV;
            S_COMMIT: w_state_next = (value_vld || r_pend_vld) ? S_CONV : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Conversion FSM controls; a strobe during COMMIT overrides any held pending value
    always_comb begin
        w_load     = 1'b0;
        w_load_val = value;
        w_shift    = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: w_load = value_vld;
            S_CONV: w_shift = 1'b1;
            S_COMMIT: begin
                w_commit   = 1'b1;
                w_load     = value_vld || r_pend_vld;
                w_load_val = value_vld ? value : r_pend_val;
            end
            default: w_load = 1'b0;
        endcase
    end

    assign w_adj = dabble_adjust(r_bcd);

    // Double-dabble datapath; bits shifted past the top BCD nibble are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
        end else if (w_load) begin
            r_bin      <= w_load_val;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= (64'(w_load_val) >= OVF_LIMIT);
        end else if (w_shift) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_bin <= r_bin;
        end
    end

    // Pending slot, last write wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
        end else if (w_commit) begin
            r_pend_vld <= 1'b0;
        end else if (value_vld && (r_state == S_CONV)) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= value;
        end else begin
            r_pend_vld <= r_pend_vld;
        end
    end

    // Atomic display/overflow commit and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            if (w_commit) begin
                r_disp <= r_bcd;
                r_ovf  <= r_ovf_next;
            end else begin
                r_disp <= r_disp;
            end
        end
    end

    assign w_tick = (r_presc == PW'(CLK_DIV - 1));

    // Scan prescaler, digit counter and blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_digit   <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_digit <= (r_digit == DW'(NUM_DIGITS - 1)) ? DW'(0) : r_digit + DW'(1);
            if (r_blk_cnt == BKW'(BLINK_TICKS - 1)) begin
                r_blk_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + BKW'(1);
            end
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Bit k set when digit k and every digit above it are zero
    always_comb begin
        logic v_acc;
        v_acc        = 1'b1;
        w_upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_acc           = v_acc && (r_disp[4*k +: 4] == 4'd0);
            w_upper_zero[k] = v_acc;
        end
    end

    assign w_nibble = r_disp[4*r_digit +: 4];

    // Per-digit segment selection with blink > overflow > blanking > decode priority
    always_comb begin
        w_sel_next = '1;
        w_dat_next = 7'h00;
        if (blink && r_phase) begin
            w_sel_next = '1;
            w_dat_next = 7'h00;
        end else begin
            w_sel_next = ~(NUM_DIGITS'(1) << r_digit);
            if (r_ovf) begin
                w_dat_next = 7'h40;
            end else if (lz_blank && (r_digit != DW'(0)) && w_upper_zero[r_digit]) begin
                w_dat_next = 7'h00;
            end else begin
                w_dat_next = seg_decode(w_nibble);
            end
        end
    end

    // Select and segment pins load together on the scan tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '1;
            r_dat <= 7'h00;
        end else if (w_tick) begin
            r_sel <= w_sel_next;
            r_dat <= w_dat_next;
        end else begin
            r_sel <= r_sel;
        end
    end

    assign busy       = r_busy;
    assign ovf        = r_ovf;
    assign seg_select = r_sel;
    assign seg_data   = r_dat;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against an arithmetic reference model
// (decimal digits via divide/modulo, conversion timing from commit-edge bookkeeping).
module tb_seg_scan_driver;

    localparam int ND = 8;
    localparam int BW = 27;
    localparam int CD = 4;
    localparam int BT = 3;
    localparam longint LIMIT = 64'd100000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] value = '0;
    logic          value_vld = 1'b0;
    logic          lz_blank = 1'b0;
    logic          blink = 1'b0;
    logic          busy;
    logic          ovf;
    logic [ND-1:0] seg_select;
    logic [6:0]    seg_data;

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .CLK_DIV    (CD),
        .BLINK_TICKS(BT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .value_vld (value_vld),
        .lz_blank  (lz_blank),
        .blink     (blink),
        .busy      (busy),
        .ovf       (ovf),
        .seg_select(seg_select),
        .seg_data  (seg_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    bit mon_en = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic longint p10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Reference model state
    longint        edges;
    bit            m_active;
    longint        m_commit_at;
    longint        m_cur;
    bit            m_pvld;
    longint        m_pval;
    longint        m_disp;
    bit            m_ovf;
    logic [ND-1:0] e_sel;
    logic [6:0]    e_dat;
    bit            e_off;

    function automatic logic [6:0] exp_data(input int d);
        longint digit;
        if (m_ovf) return 7'h40;
        digit = (m_disp / p10(d)) % 10;
        if (lz_blank && d > 0 && m_disp < p10(d)) return 7'h00;
        return seg_tab[digit];
    endfunction

    // Reference model: tick outputs use the display as it stands before this edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges <= 0; m_active <= 1'b0; m_commit_at <= 0; m_cur <= 0;
            m_pvld <= 1'b0; m_pval <= 0; m_disp <= 0; m_ovf <= 1'b0;
            e_sel <= '1; e_dat <= 7'h00; e_off <= 1'b0;
        end else begin
            edges <= edges + 1;
            if (edges % CD == CD - 1) begin
                e_off <= blink && (((edges / CD) / BT) % 2 == 1);
                e_sel <= (blink && (((edges / CD) / BT) % 2 == 1)) ? {ND{1'b1}}
                                                                   : ~(ND'(1) << ((edges / CD) % ND));
                e_dat <= exp_data(int'((edges / CD) % ND));
            end
            if (m_active && edges == m_commit_at) begin
                m_disp <= m_cur;
                m_ovf  <= (m_cur >= LIMIT);
                if (value_vld) begin
                    m_cur <= longint'(value); m_commit_at <= edges + BW + 1; m_pvld <= 1'b0;
                end else if (m_pvld) begin
                    m_cur <= m_pval; m_commit_at <= edges + BW + 1; m_pvld <= 1'b0;
                end else begin
                    m_active <= 1'b0;
                end
            end else if (value_vld) begin
                if (m_active) begin
                    m_pvld <= 1'b1; m_pval <= longint'(value);
                end else begin
                    m_active <= 1'b1; m_cur <= longint'(value); m_commit_at <= edges + BW + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check_eq("seg_select", seg_select, e_sel);
            if (!e_off) check_eq("seg_data", seg_data, e_dat);
            check_eq("busy", busy, m_active);
            check_eq("ovf", ovf, m_ovf);
        end
    end

    task automatic send(input longint v);
        @(negedge clk);
        value = BW'(v);
        value_vld = 1'b1;
        @(negedge clk);
        value_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (m_active && i < 1000) begin
            @(negedge clk);
            i++;
        end
        check_eq("idle_wait", (i < 1000), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sel"}, seg_select, {ND{1'b1}});
        check_eq({tag, "_data"}, seg_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        lz_blank = 1'b1;
        repeat (2 * ND * CD) @(negedge clk);
        lz_blank = 1'b0;
        repeat (ND * CD) @(negedge clk);

        send(12345678);
        wait_idle();
        repeat (ND * CD + CD) @(negedge clk);
        send(100000000);
        wait_idle();
        repeat (ND * CD + CD) @(negedge clk);
        lz_blank = 1'b1;
        send(0);
        wait_idle();
        repeat (ND * CD + CD) @(negedge clk);

        send(5);
        repeat (3) @(negedge clk);
        send(9);
        repeat (5) @(negedge clk);
        send(42);
        wait_idle();
        repeat (ND * CD) @(negedge clk);

        send(7);
        repeat (BW - 1) @(negedge clk);
        send(88);
        wait_idle();
        repeat (ND * CD) @(negedge clk);

        blink = 1'b1;
        send(314159);
        repeat (BT * CD * 6) @(negedge clk);
        blink = 1'b0;
        repeat (ND * CD) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            lz_blank = 1'($urandom_range(0, 1));
            blink = ($urandom_range(0, 3) == 0);
            send(longint'($urandom_range(0, (1 << BW) - 1)) / longint'(1 << $urandom_range(0, 20)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        blink = 1'b0;
        repeat (ND * CD) @(negedge clk);

        send(120000000);
        wait_idle();
        repeat (CD) @(negedge clk);
        send(999);
        repeat (10) @(negedge clk);
        send(555);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_conv_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * ND * CD) @(negedge clk);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
